instr_mem_loadable: RTL and testbench
=====================================

Name: instr_mem_loadable

Overview:
- Next-generation instruction memory for the pipelined MIPS core: byte-addressed, little-endian, depth-parametrised.
- Adds a runtime byte loader, so the bench or a boot UART can stream programs without editing source.
- Fetch has a registered 1-cycle read with stall-hold and fetch error flags.
- Sits between the PC stage and the IF/ID pipeline register.

Parameters:
- ADDR_W, 10, byte-address bits used for the array index.
- DEPTH_BYTES, 1024, array size in bytes. Must be a multiple of 4 and no more than 2^ADDR_W.
- NOP_WORD, 32'h0000_0000, word returned on a fetch error (sll $0,$0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_start  in  1  pulse: enter LOAD and clear the load pointer.
- run_start  in  1  pulse: enter RUN from IDLE using the current contents.
- load_valid  in  1  load_byte is valid this cycle.
- load_byte  in  8  program byte, written at the load pointer.
- load_last  in  1  qualifies the final byte of the program.
- par_inject  in  1  corrupts the parity of the byte being written; only effective with the macro.
- load_ready  out  1  1 while in LOAD.
- load_count  out  ADDR_W+1  bytes written in the current load.
- load_overflow  out  1  sticky: bytes were dropped past DEPTH_BYTES.
- running  out  1  1 in RUN.
- fetch_req  in  1  fetch request.
- fetch_stall  in  1  hold the current fetch output.
- fetch_addr  in  32  PC byte address.
- instr  out  32  fetched word, {M[a+3],M[a+2],M[a+1],M[a]}.
- instr_valid  out  1  instr corresponds to an accepted request.
- err_misaligned  out  1  accepted request had fetch_addr[1:0] != 0.
- err_oob  out  1  accepted request had fetch_addr > DEPTH_BYTES-4.
- parity_err  out  1  parity mismatch on the fetched word.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, pointer=0, load_count=0.
  - load_overflow=0, instr=0, instr_valid=0, all err flags=0, load_ready=0, running=0.
  - The memory array is NOT cleared by reset. Power-up contents are all zero.
- FSM transitions:
  - IDLE->LOAD on load_start.
  - IDLE->RUN on run_start.
  - LOAD->RUN on an accepted byte with load_last=1.
  - RUN->LOAD on load_start.
  - LOAD->LOAD on load_start restarts the load: pointer=0, count=0, overflow cleared.
  - load_start has priority over run_start when both are asserted.
- Load writes:
  - In LOAD with load_valid=1, write load_byte to M[pointer], then pointer++ and load_count++. load_ready stays 1 for the whole LOAD state.
  - When pointer==DEPTH_BYTES, further bytes are accepted but dropped. load_overflow sets and stays set; load_count saturates.
  - load_last is still honoured when overflowing.
  - Bytes already written are retained across reset and across an aborted load.
- Fetch (RUN only, latency 1):
  - If fetch_req=1 and fetch_stall=0, the request is accepted. Next cycle: instr=word, instr_valid=1, and the err flags reflect that request.
  - On misaligned or out-of-bounds requests: instr=NOP_WORD, instr_valid=1, and the matching err flag is set. Both flags may be set together.
  - If fetch_stall=1: instr, instr_valid and the err flags hold, regardless of fetch_req.
  - If fetch_req=0 and fetch_stall=0: instr_valid=0 and err flags=0; instr holds its last value.
- Outside RUN:
  - Fetch inputs are ignored and instr_valid=0.
  - On RUN->LOAD, instr_valid drops in the same cycle the state becomes LOAD, even if a stall is active.
- The loader and fetch never access the array in the same cycle, since they are mutually exclusive by state.

Optional Feature:
- Macro: INSTR_MEM_PARITY_EN.
- With the macro defined:
  - Each byte is stored with an even-parity bit computed at load write. The bit is inverted when par_inject=1.
  - On an in-bounds, aligned fetch, the 4 parity bits are checked. parity_err=1 alongside instr_valid on any mismatch; instr is still delivered unmodified.
  - parity_err follows the same hold and clear rules as the err flags.
- Without the macro: no parity storage, par_inject is ignored, and parity_err is tied to 0.

Test Plan:
- Load 0x20,0x58,0x2A,0x05 with last on the 4th byte, then fetch 0x0 -> running=1, load_count=4, and next cycle instr=0x052A5820 with instr_valid=1.
- In RUN: fetch 0x2 -> instr=0x00000000, err_misaligned=1. Fetch 0x3FE -> err_oob=1 and err_misaligned=1. Fetch 0x3FC -> instr=M[0x3FC..0x3FF], no errors.
- Fetch 0x0 and accept it, then hold fetch_stall=1 for 3 cycles while fetch_addr changes to 0x4 -> instr=0x052A5820 and instr_valid=1 held throughout. Releasing the stall with fetch_req=0 gives instr_valid=0.
- Stream 1030 bytes without last -> load_overflow=1 and load_count=1024. Then load_last -> RUN. Then load_start -> overflow=0 and count=0.
- Assert rst_n=0 asynchronously mid-load after 2 bytes -> IDLE, outputs 0. Then run_start and fetch 0x0 -> bytes 0..1 are new and bytes 2..3 keep their previous contents.
- With INSTR_MEM_PARITY_EN, load 4 bytes with par_inject=1 on byte 2, then fetch 0x0 -> parity_err=1 and the instr value is intact. Without the macro, parity_err=0.

Source files
------------

// File: rtl/instr_mem_loadable.sv
// Byte-addressed little-endian instruction memory with a runtime byte loader and a registered fetch.
// Optional per-byte even parity is enabled by defining INSTR_MEM_PARITY_EN.
module instr_mem_loadable #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_start_i,
  input  logic              run_start_i,
  input  logic              load_valid_i,
  input  logic [7:0]        load_byte_i,
  input  logic              load_last_i,
  input  logic              par_inject_i,
  output logic              load_ready_o,
  output logic [ADDR_W:0]   load_count_o,
  output logic              load_overflow_o,
  output logic              running_o,
  input  logic              fetch_req_i,
  input  logic              fetch_stall_i,
  input  logic [31:0]       fetch_addr_i,
  output logic [31:0]       instr_o,
  output logic              instr_valid_o,
  output logic              err_misaligned_o,
  output logic              err_oob_o,
  output logic              parity_err_o
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W+1)'(DEPTH_BYTES);
  localparam logic [31:0]     LastWord = 32'(DEPTH_BYTES - 4);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              misal_q, misal_d;
  logic              oob_q, oob_d;
  logic              perr_q, perr_d;

  logic [7:0]        mem_q [DEPTH_BYTES];
  logic              mem_we;
  logic [ADDR_W-1:0] wr_idx;
  logic [ADDR_W-1:0] rd_idx;
  logic [31:0]       rd_word;
  logic              rd_par_bad;
  logic              req_misal;
  logic              req_oob;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next-state logic; load_start wins over run_start and over a pending byte
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (load_start_i)     state_d = StLoad;
        else if (run_start_i) state_d = StRun;
      end
      StLoad: begin
        if (!load_start_i && load_valid_i && load_last_i) state_d = StRun;
      end
      StRun: begin
        if (load_start_i) state_d = StLoad;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    load_ready_o = (state_q == StLoad);
    running_o    = (state_q == StRun);
  end

  // Loader datapath; pointer doubles as the saturating byte count
  always_comb begin
    ptr_d  = ptr_q;
    ovf_d  = ovf_q;
    mem_we = 1'b0;
    if (load_start_i && (state_q != StLoad || state_d == StLoad)) begin
      ptr_d = '0;
      ovf_d = 1'b0;
    end else if (state_q == StLoad && load_valid_i) begin
      if (ptr_q < DepthCnt) begin
        mem_we = 1'b1;
        ptr_d  = ptr_q + 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  assign wr_idx = ptr_q[ADDR_W-1:0];
  assign rd_idx = fetch_addr_i[ADDR_W-1:0];

  // Array is intentionally not reset so a program survives rst_ni
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[wr_idx] <= load_byte_i;
  end

  assign rd_word = {mem_q[rd_idx + ADDR_W'(3)], mem_q[rd_idx + ADDR_W'(2)],
                    mem_q[rd_idx + ADDR_W'(1)], mem_q[rd_idx]};

`ifdef INSTR_MEM_PARITY_EN
  logic [DEPTH_BYTES-1:0] par_q;

  always_ff @(posedge clk_i) begin
    if (mem_we) par_q[wr_idx] <= (^load_byte_i) ^ par_inject_i;
  end

  assign rd_par_bad = (^{mem_q[rd_idx],               par_q[rd_idx]})
                    | (^{mem_q[rd_idx + ADDR_W'(1)],  par_q[rd_idx + ADDR_W'(1)]})
                    | (^{mem_q[rd_idx + ADDR_W'(2)],  par_q[rd_idx + ADDR_W'(2)]})
                    | (^{mem_q[rd_idx + ADDR_W'(3)],  par_q[rd_idx + ADDR_W'(3)]});
`else
  logic unused_par_inject;
  assign unused_par_inject = par_inject_i;
  assign rd_par_bad        = 1'b0;
`endif

  assign req_misal = |fetch_addr_i[1:0];
  assign req_oob   = fetch_addr_i > LastWord;

  // Fetch outputs also clear on the edge that leaves RUN, stall or not
  always_comb begin
    instr_d = instr_q;
    valid_d = valid_q;
    misal_d = misal_q;
    oob_d   = oob_q;
    perr_d  = perr_q;
    if (state_q != StRun || state_d != StRun) begin
      valid_d = 1'b0;
      misal_d = 1'b0;
      oob_d   = 1'b0;
      perr_d  = 1'b0;
    end else if (!fetch_stall_i) begin
      if (fetch_req_i) begin
        valid_d = 1'b1;
        misal_d = req_misal;
        oob_d   = req_oob;
        instr_d = (req_misal || req_oob) ? NOP_WORD : rd_word;
        perr_d  = !(req_misal || req_oob) && rd_par_bad;
      end else begin
        valid_d = 1'b0;
        misal_d = 1'b0;
        oob_d   = 1'b0;
        perr_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
      instr_q <= '0;
      valid_q <= 1'b0;
      misal_q <= 1'b0;
      oob_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      misal_q <= misal_d;
      oob_q   <= oob_d;
      perr_q  <= perr_d;
    end
  end

  assign load_count_o     = ptr_q;
  assign load_overflow_o  = ovf_q;
  assign instr_o          = instr_q;
  assign instr_valid_o    = valid_q;
  assign err_misaligned_o = misal_q;
  assign err_oob_o        = oob_q;
  assign parity_err_o     = perr_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed self-checking bench for instr_mem_loadable (default depth 1024 bytes).
module tb_instr_mem_loadable;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_start, run_start, load_valid, load_last, par_inject;
  logic [7:0]    load_byte;
  logic          load_ready, load_overflow, running;
  logic [AW:0]   load_count;
  logic          fetch_req, fetch_stall;
  logic [31:0]   fetch_addr, instr;
  logic          instr_valid, err_misaligned, err_oob, parity_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_mem_loadable dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .load_start_i     (load_start),
    .run_start_i      (run_start),
    .load_valid_i     (load_valid),
    .load_byte_i      (load_byte),
    .load_last_i      (load_last),
    .par_inject_i     (par_inject),
    .load_ready_o     (load_ready),
    .load_count_o     (load_count),
    .load_overflow_o  (load_overflow),
    .running_o        (running),
    .fetch_req_i      (fetch_req),
    .fetch_stall_i    (fetch_stall),
    .fetch_addr_i     (fetch_addr),
    .instr_o          (instr),
    .instr_valid_o    (instr_valid),
    .err_misaligned_o (err_misaligned),
    .err_oob_o        (err_oob),
    .parity_err_o     (parity_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input logic inj);
    load_valid = 1'b1;
    load_byte  = b;
    load_last  = last;
    par_inject = inj;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
    par_inject = 1'b0;
  endtask

  task automatic pulse_load_start;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  // One accepted request; outputs are checked one cycle later by the caller
  task automatic fetch(input logic [31:0] a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    tick();
    fetch_req  = 1'b0;
  endtask

  task automatic check_fetch(input string tag, input logic [31:0] exp_instr,
                             input logic exp_mis, input logic exp_oob, input logic exp_par);
    check({tag, ".instr"}, instr, exp_instr);
    check({tag, ".valid"}, 32'(instr_valid), 32'd1);
    check({tag, ".mis"},   32'(err_misaligned), 32'(exp_mis));
    check({tag, ".oob"},   32'(err_oob), 32'(exp_oob));
    check({tag, ".par"},   32'(parity_err), 32'(exp_par));
  endtask

  initial begin
    logic exp_par_inj;
`ifdef INSTR_MEM_PARITY_EN
    exp_par_inj = 1'b1;
`else
    exp_par_inj = 1'b0;
`endif
    rst_n = 1'b0;
    {load_start, run_start, load_valid, load_last, par_inject} = '0;
    load_byte = 8'h00; fetch_req = 1'b0; fetch_stall = 1'b0; fetch_addr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.ready",  32'(load_ready), 32'd0);
    check("rst.run",    32'(running), 32'd0);
    check("rst.count",  32'(load_count), 32'd0);
    check("rst.ovf",    32'(load_overflow), 32'd0);
    check("rst.instr",  instr, 32'd0);
    check("rst.valid",  32'(instr_valid), 32'd0);
    check("rst.errs",   32'({err_misaligned, err_oob, parity_err}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // load_start beats run_start in IDLE
    load_start = 1'b1; run_start = 1'b1;
    tick();
    load_start = 1'b0; run_start = 1'b0;
    check("prio.ready", 32'(load_ready), 32'd1);
    check("prio.run",   32'(running), 32'd0);

    send_byte(8'h20, 1'b0, 1'b0);
    send_byte(8'h58, 1'b0, 1'b0);
    send_byte(8'h2A, 1'b0, 1'b0);
    check("ld.ready",   32'(load_ready), 32'd1);
    send_byte(8'h05, 1'b1, 1'b0);
    check("ld.run",     32'(running), 32'd1);
    check("ld.count",   32'(load_count), 32'd4);
    check("ld.ready0",  32'(load_ready), 32'd0);

    fetch(32'h0);
    check_fetch("f0", 32'h052A5820, 1'b0, 1'b0, 1'b0);
    fetch(32'h2);
    check_fetch("f2", 32'h0, 1'b1, 1'b0, 1'b0);
    fetch(32'h3FE);
    check_fetch("f3fe", 32'h0, 1'b1, 1'b1, 1'b0);
    fetch(32'h400);
    check_fetch("f400", 32'h0, 1'b0, 1'b1, 1'b0);

    // Stall holds the accepted result while the address changes
    fetch(32'h0);
    fetch_req = 1'b1; fetch_stall = 1'b1; fetch_addr = 32'h4;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall.instr", instr, 32'h052A5820);
      check("stall.valid", 32'(instr_valid), 32'd1);
    end
    fetch_req = 1'b0; fetch_stall = 1'b0;
    tick();
    check("rel.valid", 32'(instr_valid), 32'd0);
    check("rel.instr", instr, 32'h052A5820);

    // Overflow: 1030 bytes into a 1024-byte array
    pulse_load_start();
    check("ov.count0", 32'(load_count), 32'd0);
    for (int i = 0; i < 1030; i++) send_byte(8'(i), 1'b0, 1'b0);
    check("ov.flag",   32'(load_overflow), 32'd1);
    check("ov.count",  32'(load_count), 32'd1024);
    check("ov.ready",  32'(load_ready), 32'd1);
    send_byte(8'hEE, 1'b1, 1'b0);
    check("ov.run",    32'(running), 32'd1);
    check("ov.sticky", 32'(load_overflow), 32'd1);
    check("ov.count2", 32'(load_count), 32'd1024);
    fetch(32'h3FC);
    check_fetch("f3fc", 32'hFFFEFDFC, 1'b0, 1'b0, 1'b0);
    fetch(32'h0);
    check_fetch("fov0", 32'h03020100, 1'b0, 1'b0, 1'b0);

    // RUN->LOAD drops instr_valid immediately even under stall
    fetch_req = 1'b1; fetch_stall = 1'b1; load_start = 1'b1;
    tick();
    fetch_req = 1'b0; fetch_stall = 1'b0; load_start = 1'b0;
    check("rl.ready",  32'(load_ready), 32'd1);
    check("rl.valid",  32'(instr_valid), 32'd0);
    check("rl.ovf",    32'(load_overflow), 32'd0);
    check("rl.count",  32'(load_count), 32'd0);

    // Asynchronous reset mid-load after two bytes
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'hBB, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("ar.ready",  32'(load_ready), 32'd0);
    check("ar.count",  32'(load_count), 32'd0);
    check("ar.run",    32'(running), 32'd0);
    check("ar.instr",  instr, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    check("ar.run1",   32'(running), 32'd1);
    fetch(32'h0);
    check_fetch("far", 32'h0302BBAA, 1'b0, 1'b0, 1'b0);

    // Parity injection on byte 2
    pulse_load_start();
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b1);
    send_byte(8'h44, 1'b1, 1'b0);
    fetch(32'h0);
    check_fetch("fpar", 32'h44332211, 1'b0, 1'b0, exp_par_inj);
    fetch(32'h4);
    check_fetch("fpar4", 32'h07060504, 1'b0, 1'b0, 1'b0);
    tick();
    check("idle.valid", 32'(instr_valid), 32'd0);
    check("idle.par",   32'(parity_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
